// File: rtl/hpdcache_wbuf_flush_ctrl_if.sv
// Bundle of the write-buffer flush controller signals, excluding clock and reset.
interface hpdcache_wbuf_flush_ctrl_if #(
  parameter int unsigned ENTRIES       = 16,
  parameter int unsigned TIMECNT_WIDTH = 4
);
  localparam int unsigned IDXW = $clog2(ENTRIES);

  logic [TIMECNT_WIDTH-1:0] cfg_threshold_i;
  logic                     cfg_reset_timecnt_on_write_i;
  logic                     alloc_i;
  logic [IDXW-1:0]          alloc_idx_i;
  logic                     write_i;
  logic [IDXW-1:0]          write_idx_i;
  logic                     flush_all_i;
  logic                     send_valid_o;
  logic [IDXW-1:0]          send_idx_o;
  logic                     send_ready_i;
  logic                     ack_i;
  logic [IDXW-1:0]          ack_idx_i;
  logic [ENTRIES-1:0]       free_o;
  logic                     full_o;
  logic                     empty_o;

  // Requester / memory side: drives controls, observes status.
  modport master (
    output cfg_threshold_i, cfg_reset_timecnt_on_write_i,
    output alloc_i, alloc_idx_i, write_i, write_idx_i, flush_all_i,
    output send_ready_i, ack_i, ack_idx_i,
    input  send_valid_o, send_idx_o, free_o, full_o, empty_o
  );

  // Controller side.
  modport slave (
    input  cfg_threshold_i, cfg_reset_timecnt_on_write_i,
    input  alloc_i, alloc_idx_i, write_i, write_idx_i, flush_all_i,
    input  send_ready_i, ack_i, ack_idx_i,
    output send_valid_o, send_idx_o, free_o, full_o, empty_o
  );
endinterface

// File: rtl/hpdcache_wbuf_flush_ctrl.sv
// Write-buffer directory flush controller: per-entry FREE/OPEN/PEND/SENT
// tracking, threshold-based closing, lowest-index send arbitration with lock.
module hpdcache_wbuf_flush_ctrl #(
  parameter int unsigned ENTRIES       = 16,
  parameter int unsigned TIMECNT_WIDTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  hpdcache_wbuf_flush_ctrl_if.slave bus
);
  localparam int unsigned IDXW = $clog2(ENTRIES);

  typedef enum logic [1:0] {FREE, OPEN, PEND, SENT} state_t;

  state_t                   state_q [ENTRIES];
  state_t                   state_d [ENTRIES];
  logic [TIMECNT_WIDTH-1:0] cnt_q   [ENTRIES];
  logic [TIMECNT_WIDTH-1:0] cnt_d   [ENTRIES];
  logic                     lock_q, lock_d;
  logic [IDXW-1:0]          lock_idx_q, lock_idx_d;

  logic                     pend_any;
  logic [IDXW-1:0]          pend_idx;
  logic [IDXW-1:0]          send_idx;
  logic                     send_fire;
  logic [ENTRIES-1:0]       free_vec;

  // State, counter and send-lock registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        state_q[i] <= FREE;
        cnt_q[i]   <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Lowest-index PEND entry and FREE bitmap from registered state.
  always_comb begin
    pend_any = 1'b0;
    pend_idx = '0;
    free_vec = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      free_vec[i] = (state_q[i] == FREE);
      if (state_q[i] == PEND) begin
        pend_any = 1'b1;
        pend_idx = IDXW'(i);
      end
    end
  end

  // A locked index stays selected until its handshake completes.
  assign send_idx  = lock_q ? lock_idx_q : pend_idx;
  assign send_fire = pend_any & bus.send_ready_i;

  // Per-entry next state; states are disjoint so events on different entries never collide.
  always_comb begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;

    for (int i = 0; i < int'(ENTRIES); i++) begin
      unique case (state_q[i])
        FREE: begin
          if (bus.alloc_i && (bus.alloc_idx_i == IDXW'(i))) begin
            state_d[i] = OPEN;
            cnt_d[i]   = '0;
          end
        end
        OPEN: begin
          if (bus.flush_all_i) begin
            state_d[i] = PEND;
          end else if (bus.write_i && bus.cfg_reset_timecnt_on_write_i &&
                       (bus.write_idx_i == IDXW'(i))) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == bus.cfg_threshold_i) begin
            state_d[i] = PEND;
          end else if (cnt_q[i] != {TIMECNT_WIDTH{1'b1}}) begin
            cnt_d[i] = cnt_q[i] + TIMECNT_WIDTH'(1);
          end
        end
        PEND: begin
          if (send_fire && (send_idx == IDXW'(i))) begin
            state_d[i] = SENT;
          end
        end
        SENT: begin
          if (bus.ack_i && (bus.ack_idx_i == IDXW'(i))) begin
            state_d[i] = FREE;
          end
        end
        default: state_d[i] = FREE;
      endcase
    end

    if (send_fire) begin
      lock_d = 1'b0;
    end else if (pend_any) begin
      lock_d     = 1'b1;
      lock_idx_d = send_idx;
    end
  end

  assign bus.send_valid_o = pend_any;
  assign bus.send_idx_o   = send_idx;
  assign bus.free_o       = free_vec;
  assign bus.full_o       = ~|free_vec;
  assign bus.empty_o      = &free_vec;

endmodule

// File: tb/tb_hpdcache_wbuf_flush_ctrl.sv
// Directed self-checking bench for the write-buffer flush controller.
module tb_hpdcache_wbuf_flush_ctrl;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hpdcache_wbuf_flush_ctrl_if #(.ENTRIES(16), .TIMECNT_WIDTH(4)) bus ();

  hpdcache_wbuf_flush_ctrl #(.ENTRIES(16), .TIMECNT_WIDTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_threshold_i              = 4'd3;
    bus.cfg_reset_timecnt_on_write_i = 1'b0;
    bus.alloc_i      = 1'b0;
    bus.alloc_idx_i  = '0;
    bus.write_i      = 1'b0;
    bus.write_idx_i  = '0;
    bus.flush_all_i  = 1'b0;
    bus.send_ready_i = 1'b0;
    bus.ack_i        = 1'b0;
    bus.ack_idx_i    = '0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 32'(bus.send_valid_o), 32'd0);
    chk("rst_idx",   32'(bus.send_idx_o),   32'd0);
    chk("rst_free",  32'(bus.free_o),       32'hffff);
    chk("rst_full",  32'(bus.full_o),       32'd0);
    chk("rst_empty", 32'(bus.empty_o),      32'd1);

    // T=3, alloc idx 5 in cycle A -> PEND in A+5
    bus.cfg_threshold_i = 4'd3;
    bus.alloc_i = 1'b1; bus.alloc_idx_i = 4'd5;
    tick();
    bus.alloc_i = 1'b0;
    chk("t1_free",  32'(bus.free_o),  32'hffdf);
    chk("t1_empty", 32'(bus.empty_o), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("t1_open_valid", 32'(bus.send_valid_o), 32'd0);
      tick();
    end
    chk("t1_pend_valid", 32'(bus.send_valid_o), 32'd1);
    chk("t1_pend_idx",   32'(bus.send_idx_o),   32'd5);
    bus.send_ready_i = 1'b1;
    tick();
    bus.send_ready_i = 1'b0;
    chk("t1_sent_valid", 32'(bus.send_valid_o), 32'd0);
    chk("t1_sent_free",  32'(bus.free_o),       32'hffdf);
    bus.ack_i = 1'b1; bus.ack_idx_i = 4'd5;
    tick();
    bus.ack_i = 1'b0;
    chk("t1_ack_free",  32'(bus.free_o),  32'hffff);
    chk("t1_ack_empty", 32'(bus.empty_o), 32'd1);

    // T=3, alloc idx 2 at cycle 0, writes at 3 and 4; PEND at 9 (reset-on-write) or 5
    for (int row = 1; row >= 0; row--) begin
      bus.cfg_reset_timecnt_on_write_i = row[0];
      for (int cyc = 0; cyc < 10; cyc++) begin
        bus.alloc_i     = (cyc == 0);
        bus.alloc_idx_i = 4'd2;
        bus.write_i     = (cyc == 3) || (cyc == 4);
        bus.write_idx_i = 4'd2;
        if (cyc >= 1) begin
          chk(row == 1 ? "t2_row1_valid" : "t2_row0_valid", 32'(bus.send_valid_o),
              (cyc >= (row == 1 ? 9 : 5)) ? 32'd1 : 32'd0);
          chk(row == 1 ? "t2_row1_idx" : "t2_row0_idx", 32'(bus.send_idx_o),
              (cyc >= (row == 1 ? 9 : 5)) ? 32'd2 : 32'd0);
        end
        tick();
      end
      bus.alloc_i = 1'b0; bus.write_i = 1'b0;
      bus.send_ready_i = 1'b1;
      tick();
      bus.send_ready_i = 1'b0;
      bus.ack_i = 1'b1; bus.ack_idx_i = 4'd2;
      tick();
      bus.ack_i = 1'b0;
      chk("t2_empty", 32'(bus.empty_o), 32'd1);
    end
    bus.cfg_reset_timecnt_on_write_i = 1'b0;

    // Send lock: idx 6 PEND with ready low, idx 1 goes PEND later
    bus.cfg_threshold_i = 4'd0;
    bus.alloc_i = 1'b1; bus.alloc_idx_i = 4'd6;
    tick();
    bus.alloc_i = 1'b0;
    chk("t3_open_valid", 32'(bus.send_valid_o), 32'd0);
    tick();
    chk("t3_pend6_valid", 32'(bus.send_valid_o), 32'd1);
    chk("t3_pend6_idx",   32'(bus.send_idx_o),   32'd6);
    bus.alloc_i = 1'b1; bus.alloc_idx_i = 4'd1;
    tick();
    bus.alloc_i = 1'b0;
    chk("t3_lock_idx_a", 32'(bus.send_idx_o), 32'd6);
    tick();
    chk("t3_lock_idx_b",   32'(bus.send_idx_o),   32'd6);
    chk("t3_lock_valid_b", 32'(bus.send_valid_o), 32'd1);
    tick();
    chk("t3_lock_idx_c", 32'(bus.send_idx_o), 32'd6);
    bus.send_ready_i = 1'b1;
    tick();
    bus.send_ready_i = 1'b0;
    chk("t3_next_valid", 32'(bus.send_valid_o), 32'd1);
    chk("t3_next_idx",   32'(bus.send_idx_o),   32'd1);
    bus.send_ready_i = 1'b1;
    tick();
    bus.send_ready_i = 1'b0;
    chk("t3_done_valid", 32'(bus.send_valid_o), 32'd0);
    chk("t3_done_free",  32'(bus.free_o),       32'hffbd);
    bus.ack_i = 1'b1; bus.ack_idx_i = 4'd6;
    tick();
    bus.ack_idx_i = 4'd1;
    tick();
    bus.ack_i = 1'b0;
    chk("t3_empty", 32'(bus.empty_o), 32'd1);

    // Fill all 16 entries, flush, send and ack everything
    bus.cfg_threshold_i = 4'd15;
    for (int i = 0; i < 16; i++) begin
      bus.alloc_i = 1'b1; bus.alloc_idx_i = 4'(i);
      tick();
    end
    bus.alloc_i = 1'b0;
    chk("t4_full",  32'(bus.full_o),       32'd1);
    chk("t4_free",  32'(bus.free_o),       32'h0);
    chk("t4_valid", 32'(bus.send_valid_o), 32'd0);
    bus.flush_all_i = 1'b1;
    tick();
    bus.flush_all_i = 1'b0;
    bus.send_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_send_valid", 32'(bus.send_valid_o), 32'd1);
      chk("t4_send_idx",   32'(bus.send_idx_o),   32'(i));
      tick();
    end
    bus.send_ready_i = 1'b0;
    chk("t4_all_sent_valid", 32'(bus.send_valid_o), 32'd0);
    chk("t4_all_sent_full",  32'(bus.full_o),       32'd1);
    for (int i = 0; i < 16; i++) begin
      bus.ack_i = 1'b1; bus.ack_idx_i = 4'(i);
      tick();
    end
    bus.ack_i = 1'b0;
    chk("t4_empty", 32'(bus.empty_o), 32'd1);
    chk("t4_free_all", 32'(bus.free_o), 32'hffff);

    // Same-cycle flush and alloc idx 0 with idx 3 already OPEN
    bus.alloc_i = 1'b1; bus.alloc_idx_i = 4'd3;
    tick();
    bus.alloc_i = 1'b1; bus.alloc_idx_i = 4'd0; bus.flush_all_i = 1'b1;
    tick();
    bus.alloc_i = 1'b0; bus.flush_all_i = 1'b0;
    chk("t5_valid", 32'(bus.send_valid_o), 32'd1);
    chk("t5_idx",   32'(bus.send_idx_o),   32'd3);
    chk("t5_free",  32'(bus.free_o),       32'hfff6);
    bus.send_ready_i = 1'b1;
    tick();
    bus.send_ready_i = 1'b0;
    chk("t5_idx0_open", 32'(bus.send_valid_o), 32'd0);

    // Mid-operation reset with OPEN/PEND/SENT entries; later ack ignored
    bus.alloc_i = 1'b1; bus.alloc_idx_i = 4'd7;
    tick();
    bus.alloc_idx_i = 4'd9;
    tick();
    bus.alloc_i = 1'b0; bus.flush_all_i = 1'b1;
    tick();
    bus.flush_all_i = 1'b0;
    bus.alloc_i = 1'b1; bus.alloc_idx_i = 4'd12;
    tick();
    bus.alloc_i = 1'b0;
    chk("t6_pre_valid", 32'(bus.send_valid_o), 32'd1);
    chk("t6_pre_idx",   32'(bus.send_idx_o),   32'd0);
    chk("t6_pre_free",  32'(bus.free_o),       32'hed76);
    rst = 1'b1;
    bus.ack_i = 1'b1; bus.ack_idx_i = 4'd3;
    bus.send_ready_i = 1'b1;
    bus.alloc_i = 1'b1; bus.alloc_idx_i = 4'd4;
    tick();
    rst = 1'b0;
    bus.send_ready_i = 1'b0; bus.alloc_i = 1'b0;
    chk("t6_rst_empty", 32'(bus.empty_o),      32'd1);
    chk("t6_rst_valid", 32'(bus.send_valid_o), 32'd0);
    chk("t6_rst_idx",   32'(bus.send_idx_o),   32'd0);
    tick();
    bus.ack_i = 1'b0;
    chk("t6_ack_ignored_free",  32'(bus.free_o),  32'hffff);
    chk("t6_ack_ignored_empty", 32'(bus.empty_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
